// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register and req/ack instruction-fetch sequencer with misalignment and timeout error detection.
// Optional feature macro: FETCH_PERF_CNT_EN adds perf_fetches and perf_wait_cycles counters.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_new,
    input  logic        pc_load,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic        fetch_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetches,
    output logic [31:0] perf_wait_cycles
`endif
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            req_q, req_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Next-state and next-register values; the request is registered off the next state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (pc_load) begin
                    valid_d = 1'b0;
                    if (pc_new[1:0] == 2'b00) begin
                        pc_d    = pc_new;
                        state_d = FETCH;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end
                end
            end
            ERR: begin
                valid_d = 1'b0;
                err_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        req_d = (state_d == FETCH);
    end

    // State and datapath registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign fetch_err   = err_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetches_q, perf_fetches_d;
    logic [31:0] perf_wait_q, perf_wait_d;

    // Count accepted responses and FETCH cycles spent waiting for one.
    always_comb begin
        perf_fetches_d = perf_fetches_q + ((state_q == FETCH && imem_ack) ? 32'd1 : 32'd0);
        perf_wait_d    = perf_wait_q + ((state_q == FETCH && !imem_ack) ? 32'd1 : 32'd0);
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetches_q <= '0;
            perf_wait_q    <= '0;
        end else begin
            perf_fetches_q <= perf_fetches_d;
            perf_wait_q    <= perf_wait_d;
        end
    end

    assign perf_fetches     = perf_fetches_q;
    assign perf_wait_cycles = perf_wait_q;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for instr_fetch_unit (optionally with FETCH_PERF_CNT_EN).
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_new;
    logic        pc_load;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic        fetch_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetches;
    logic [31:0] perf_wait_cycles;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    instr_fetch_unit #(.RESET_PC(32'h0), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .pc_new(pc_new), .pc_load(pc_load),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ack(imem_ack), .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .fetch_err(fetch_err)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetches(perf_fetches), .perf_wait_cycles(perf_wait_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expects imem_req already high for address a; waits d cycles, then acks with data.
    task automatic do_fetch(input logic [31:0] a, input int d, input logic [31:0] data, input bit try_load);
        for (int i = 0; i < d; i++) begin
            check_eq("req_wait", imem_req, 1'b1);
            check_eq("addr_wait", imem_addr, a);
            if (try_load) begin
                pc_load = 1'b1;
                pc_new  = 32'h0000_0100;
            end
            step();
            pc_load = 1'b0;
            check_eq("pc_fetch_ignore_load", pc, a);
        end
        check_eq("req_ack", imem_req, 1'b1);
        check_eq("addr_ack", imem_addr, a);
        imem_ack   = 1'b1;
        imem_rdata = data;
        exp_q.push_back(data);
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check_eq("valid_after_ack", instr_valid, 1'b1);
        check_eq("req_after_ack", imem_req, 1'b0);
        check_eq("sb_instr", instr, exp_q.pop_front());
    endtask

    task automatic load_pc(input logic [31:0] a);
        pc_load = 1'b1;
        pc_new  = a;
        step();
        pc_load = 1'b0;
        pc_new  = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_req", imem_req, 1'b0);
        check_eq("rst_valid", instr_valid, 1'b0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_err", fetch_err, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
`ifdef FETCH_PERF_CNT_EN
        logic [31:0] w0;
`endif
        rst_n = 1'b0; pc_load = 1'b0; pc_new = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
        step();
        do_reset();
        check_eq("idle_no_req", imem_req, 1'b0);
        step();
        check_eq("first_addr", imem_addr, 32'h0);
        do_fetch(32'h0, 0, 32'h1234_5678, 1'b0);

        imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
        step();
        imem_ack = 1'b0;
        check_eq("hold_ack_ignored_instr", instr, 32'h1234_5678);
        check_eq("hold_ack_ignored_req", imem_req, 1'b0);
        check_eq("hold_valid", instr_valid, 1'b1);

        load_pc(32'h0000_0040);
        check_eq("load_req", imem_req, 1'b1);
        check_eq("load_addr", imem_addr, 32'h40);
        check_eq("load_pc", pc, 32'h40);
        check_eq("load_valid", instr_valid, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        w0 = perf_wait_cycles;
        check_eq("perf_fetches_pre", perf_fetches, 32'd1);
`endif
        do_fetch(32'h40, 3, 32'hCAFE_0001, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        check_eq("perf_wait_delta", perf_wait_cycles - w0, 32'd3);
        check_eq("perf_fetches", perf_fetches, 32'd2);
`endif

        load_pc(32'h0000_0080);
        do_fetch(32'h80, 2, 32'hCAFE_0002, 1'b1);
        load_pc(32'hFFFF_FFFC);
        check_eq("high_pc", pc, 32'hFFFF_FFFC);
        do_fetch(32'hFFFF_FFFC, 1, 32'hCAFE_0003, 1'b0);
        load_pc(32'h0000_0084);
        do_fetch(32'h84, 0, 32'hCAFE_0004, 1'b0);

        load_pc(32'h0000_0042);
        check_eq("mis_err", fetch_err, 1'b1);
        check_eq("mis_pc", pc, 32'h84);
        check_eq("mis_valid", instr_valid, 1'b0);
        check_eq("mis_req", imem_req, 1'b0);
        load_pc(32'h0000_0048);
        imem_ack = 1'b1;
        step();
        step();
        imem_ack = 1'b0;
        check_eq("err_stuck_req", imem_req, 1'b0);
        check_eq("err_stuck_pc", pc, 32'h84);
        check_eq("err_sticky", fetch_err, 1'b1);
        do_reset();
        step();
        for (int i = 0; i < 16; i++) begin
            check_eq("to_req", imem_req, 1'b1);
            check_eq("to_no_err", fetch_err, 1'b0);
            step();
        end
        check_eq("to_err", fetch_err, 1'b1);
        check_eq("to_req_drop", imem_req, 1'b0);
        check_eq("to_valid", instr_valid, 1'b0);
        do_reset();
        step();
        check_eq("mid_req", imem_req, 1'b1);
        imem_ack = 1'b1; imem_rdata = 32'h7777_7777; rst_n = 1'b0;
        step();
        imem_ack = 1'b0; rst_n = 1'b1;
        check_eq("mid_valid", instr_valid, 1'b0);
        check_eq("mid_pc", pc, 32'h0);
        check_eq("mid_instr", instr, 32'h0);
        check_eq("mid_req_low", imem_req, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        check_eq("perf_rst", perf_fetches, 32'd0);
`endif
        step();
        do_fetch(32'h0, 1, 32'hBEEF_0005, 1'b0);
        check_eq("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
